int_isq: RTL
============

# int_isq

Integer issue queue at the receiving end of the dispatch-to-integer-issue-queue enqueue interface. It accepts one dispatched micro-op per cycle and holds it with per-source sleep bits. Sleep bits are cleared by writeback wakeups. Each cycle the oldest entry with both sources awake is issued to the integer execution unit under a valid/ready handshake; a flush empties the queue.

## Interface
- DEPTH, 8: entry count, power of two, 2..32.
- DATA_WIDTH, 281: `ISQ_DATA_WIDTH; enqueue payload width.
- PREG_W, 6: physical register index width.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- disp2intisq_enq_valid  in  1  enqueue request.
- disp2intisq_instr0_enq_data  in  DATA_WIDTH  payload; fields used: robid [247:241], prs1 [116:111], prs2 [110:105], src1_is_reg [104], src2_is_reg [103].
- disp2intisq_instr0_enq_condition  in  2  busy-table status at dispatch: [1] prs1 busy, [0] prs2 busy.
- intisq_can_enq  out  1  queue not full.
- intisq2disp_enq_ready  out  1  identical to intisq_can_enq.
- wb0_valid, wb1_valid  in  1 each  writeback wakeup strobes.
- wb0_prd, wb1_prd  in  PREG_W each  woken physical register.
- intisq2exu_valid  out  1  issue request.
- exu2intisq_ready  in  1  execution unit accepts.
- intisq2exu_data  out  DATA_WIDTH  payload of selected entry.
- flush_valid  in  1  pipeline flush.
- intisq_count  out  log2(DEPTH)+1  occupied entries.

## Operation
- Per entry: valid, payload, sleep1, sleep2, age row (DEPTH bits; bit j set = entry j older).
- Wake match for source s: wbN_valid && wbN_prd == prs_s && prs_s != 0, for either port.
- Enqueue fires when disp2intisq_enq_valid && intisq_can_enq && !flush_valid.
  - Target slot: lowest-index free entry.
  - sleep_s = src_s_is_reg && condition bit && !wake match this cycle.
  - Age row = current valid vector.
  - All other entries clear their age bit for the new slot.
- Enqueue with intisq_can_enq low is dropped, with no state change.
- Wakeup: every valid entry whose prs matches either port clears that sleep bit. Both ports may match the same or different entries in one cycle.
- Ready = valid && !sleep1 && !sleep2.
- Select: the ready entry with no ready older entry, found as the ready entry whose age row ANDed with the ready vector is zero.
- Issue fires on intisq2exu_valid && exu2intisq_ready.
  - The selected entry is invalidated at the edge.
  - Its column bit is cleared in all age rows.
- intisq2exu_valid = any ready && !flush_valid. intisq2exu_data = selected payload, or zero when no entry is ready.
- The selection must not change while valid is held and ready is low, unless an older entry becomes ready.
- Flush: all valid bits and the count are cleared at the edge. Flush overrides enqueue and issue in the same cycle.
- Count: +1 on enqueue, −1 on issue; both in one cycle leaves it unchanged.

## Timing
- Enqueue visible at the edge; an enqueued entry is issue-eligible at the earliest in the next cycle.
- Wakeup at cycle N makes the entry issuable in cycle N+1. Zero-cycle wake→issue is not provided.
- A wakeup coinciding with enqueue is captured at enqueue; there is no lost wakeup.
- Issue handshake: combinational valid from registered state; free at the accepting edge.
- intisq_can_enq = (count < DEPTH), derived from the registered count.
  - A slot freed by issue in cycle N is usable in cycle N+1.
  - Full and issue in the same cycle still blocks enqueue that cycle.
- Reset values:
  - All valid bits 0; count 0.
  - intisq_can_enq = 1; intisq2disp_enq_ready = 1.
  - intisq2exu_valid = 0; intisq2exu_data = 0.
  - Perf counters 0.
- Reset asserted mid-operation drops all entries immediately, asynchronously.

## Configuration
- INTISQ_PERF_EN defined:
  - Adds outputs perf_full_cycles (32) and perf_issue_cnt (32).
  - perf_full_cycles increments each cycle with count == DEPTH.
  - perf_issue_cnt increments on each issue fire.
  - Both wrap at 2^32, are cleared by reset, and are unaffected by flush.
- INTISQ_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then enqueue robid 5 with condition 2'b00 and src regs set → intisq2exu_valid=1 the next cycle with robid 5; after the ready handshake, count=0.
- Enqueue robid 1 (prs1=12 busy), then robid 2 (no busy); ready held 1 → robid 2 issues first. wb0 prd=12 in cycle 4 → robid 1 issues in cycle 5.
- Fill 8 entries with all sources sleeping → intisq_can_enq=0, count=8. A 9th enqueue is dropped. Waking one entry and issuing it makes can_enq=1 the following cycle.
- Enqueue prs2=7 busy while wb1 prd=7 in the same cycle → entry is awake and issues the next cycle.
- Three ready entries and ready=0 for 4 cycles → valid stays 1 with the oldest payload stable. Flush in cycle 5 → valid=0 and count=0 the next cycle; a concurrent enqueue is ignored.
- Under INTISQ_PERF_EN: hold full for 10 cycles with 3 issues → perf_full_cycles=10, perf_issue_cnt=3.

Source files
------------

// File: rtl/int_isq_if.sv
// Dispatch/wakeup/issue/flush bundle for the integer issue queue.
// The slave modport is the queue side; master is the surrounding pipeline.
interface int_isq_if #(
  parameter int DATA_WIDTH = 281,
  parameter int PREG_W     = 6,
  parameter int CNT_W      = 4
);
  logic                  disp2intisq_enq_valid;
  logic [DATA_WIDTH-1:0] disp2intisq_instr0_enq_data;
  logic [1:0]            disp2intisq_instr0_enq_condition;
  logic                  intisq_can_enq;
  logic                  intisq2disp_enq_ready;
  logic                  wb0_valid;
  logic [PREG_W-1:0]     wb0_prd;
  logic                  wb1_valid;
  logic [PREG_W-1:0]     wb1_prd;
  logic                  intisq2exu_valid;
  logic                  exu2intisq_ready;
  logic [DATA_WIDTH-1:0] intisq2exu_data;
  logic                  flush_valid;
  logic [CNT_W-1:0]      intisq_count;

  modport slave (
    input  disp2intisq_enq_valid, disp2intisq_instr0_enq_data, disp2intisq_instr0_enq_condition,
    input  wb0_valid, wb0_prd, wb1_valid, wb1_prd, exu2intisq_ready, flush_valid,
    output intisq_can_enq, intisq2disp_enq_ready, intisq2exu_valid, intisq2exu_data, intisq_count
  );

  modport master (
    output disp2intisq_enq_valid, disp2intisq_instr0_enq_data, disp2intisq_instr0_enq_condition,
    output wb0_valid, wb0_prd, wb1_valid, wb1_prd, exu2intisq_ready, flush_valid,
    input  intisq_can_enq, intisq2disp_enq_ready, intisq2exu_valid, intisq2exu_data, intisq_count
  );
endinterface

// File: rtl/int_isq.sv
// Integer issue queue: per-source sleep bits woken by writeback, oldest-ready issue via age matrix.
// Define INTISQ_PERF_EN to add the perf_full_cycles / perf_issue_cnt counters.
module int_isq #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 281,
  parameter int PREG_W     = 6
) (
  input  logic        clock,
  input  logic        reset,
  int_isq_if.slave    bus
`ifdef INTISQ_PERF_EN
  ,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_issue_cnt
`endif
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_sleep1;
  logic [DEPTH-1:0]      r_sleep2;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_age  [DEPTH];
  logic [CNT_W-1:0]      r_count;

  logic [DEPTH-1:0]      w_ready;
  logic [DEPTH-1:0]      w_wake1;
  logic [DEPTH-1:0]      w_wake2;
  logic [IDX_W-1:0]      w_sel_idx;
  logic [IDX_W-1:0]      w_free_idx;
  logic [DEPTH-1:0]      w_issue_vec;
  logic [DEPTH-1:0]      w_enq_vec;
  logic                  w_any_ready;
  logic                  w_can_enq;
  logic                  w_enq;
  logic                  w_issue;
  logic [PREG_W-1:0]     w_prs1;
  logic [PREG_W-1:0]     w_prs2;
  logic                  w_enq_sleep1;
  logic                  w_enq_sleep2;

  function automatic logic f_match(input logic [PREG_W-1:0] prs,
                                   input logic v0, input logic [PREG_W-1:0] p0,
                                   input logic v1, input logic [PREG_W-1:0] p1);
    return (prs != '0) && ((v0 && (p0 == prs)) || (v1 && (p1 == prs)));
  endfunction

  assign w_prs1    = bus.disp2intisq_instr0_enq_data[116 -: PREG_W];
  assign w_prs2    = bus.disp2intisq_instr0_enq_data[110 -: PREG_W];
  assign w_can_enq = (r_count < CNT_W'(DEPTH));
  assign w_enq     = bus.disp2intisq_enq_valid && w_can_enq && !bus.flush_valid;

  // A same-cycle writeback is folded into the incoming sleep bits so no wakeup is lost.
  assign w_enq_sleep1 = bus.disp2intisq_instr0_enq_data[104] && bus.disp2intisq_instr0_enq_condition[1] &&
                        !f_match(w_prs1, bus.wb0_valid, bus.wb0_prd, bus.wb1_valid, bus.wb1_prd);
  assign w_enq_sleep2 = bus.disp2intisq_instr0_enq_data[103] && bus.disp2intisq_instr0_enq_condition[0] &&
                        !f_match(w_prs2, bus.wb0_valid, bus.wb0_prd, bus.wb1_valid, bus.wb1_prd);

  // The selected entry is the ready one whose age row has no ready older entry.
  always_comb begin
    w_ready    = r_valid & ~r_sleep1 & ~r_sleep2;
    w_sel_idx  = '0;
    w_free_idx = '0;
    w_wake1    = '0;
    w_wake2    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ready[i] && ((r_age[i] & w_ready) == '0)) w_sel_idx = IDX_W'(i);
      w_wake1[i] = f_match(r_data[i][116 -: PREG_W], bus.wb0_valid, bus.wb0_prd, bus.wb1_valid, bus.wb1_prd);
      w_wake2[i] = f_match(r_data[i][110 -: PREG_W], bus.wb0_valid, bus.wb0_prd, bus.wb1_valid, bus.wb1_prd);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  assign w_any_ready = |w_ready;
  assign w_issue     = bus.intisq2exu_valid && bus.exu2intisq_ready;
  assign w_issue_vec = w_issue ? (DEPTH'(1) << w_sel_idx) : '0;
  assign w_enq_vec   = w_enq ? (DEPTH'(1) << w_free_idx) : '0;

  assign bus.intisq_can_enq        = w_can_enq;
  assign bus.intisq2disp_enq_ready = w_can_enq;
  assign bus.intisq2exu_valid      = w_any_ready && !bus.flush_valid;
  assign bus.intisq2exu_data       = w_any_ready ? r_data[w_sel_idx] : '0;
  assign bus.intisq_count          = r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid  <= '0;
      r_sleep1 <= '0;
      r_sleep2 <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_age[i]  <= '0;
      end
    end else if (bus.flush_valid) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wake1[i]) r_sleep1[i] <= 1'b0;
        if (w_wake2[i]) r_sleep2[i] <= 1'b0;
        r_age[i] <= r_age[i] & ~w_issue_vec & ~w_enq_vec;
      end
      if (w_issue) r_valid[w_sel_idx] <= 1'b0;
      if (w_enq) begin
        r_valid[w_free_idx]  <= 1'b1;
        r_data[w_free_idx]   <= bus.disp2intisq_instr0_enq_data;
        r_sleep1[w_free_idx] <= w_enq_sleep1;
        r_sleep2[w_free_idx] <= w_enq_sleep2;
        r_age[w_free_idx]    <= r_valid & ~w_issue_vec;
      end
      if (w_enq && !w_issue)      r_count <= r_count + CNT_W'(1);
      else if (w_issue && !w_enq) r_count <= r_count - CNT_W'(1);
    end
  end

`ifdef INTISQ_PERF_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_full_cycles <= '0;
      perf_issue_cnt   <= '0;
    end else begin
      if (r_count == CNT_W'(DEPTH)) perf_full_cycles <= perf_full_cycles + 32'd1;
      if (w_issue)                  perf_issue_cnt   <= perf_issue_cnt + 32'd1;
    end
  end
`endif
endmodule
